// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage feeding the main control decoder. Owns the PC,
// runs a request/acknowledge handshake to instruction memory, latches the
// returned word and presents it (with its opcode field) for execution, then
// picks the next PC from the branch/zero results of the datapath.
//
// Ports:
//   CLK            system clock, rising edge
//   resetl         asynchronous active-low reset
//   imem_req       instruction-memory request
//   imem_addr      fetch address, always equal to pc
//   imem_ack       memory returns data this cycle
//   imem_rdata     instruction word, valid with imem_ack
//   instr          latched instruction
//   opcode         instr[31:21] for the control decoder
//   instr_valid    instr/opcode valid for execution
//   pc             address of the current instruction
//   stall          downstream not ready, hold current instruction
//   branch         conditional branch from control
//   uncond_branch  unconditional branch from control
//   zero           ALU zero flag
//   signext_imm    sign-extended branch offset in words
//   fetch_fault    sticky fetch timeout flag
//
// Configuration macro: FETCH_TIMEOUT_EN
//   Defined   - a wait counter aborts a fetch that is not acknowledged within
//               TIMEOUT request cycles, raising fetch_fault and entering HALT.
//   Undefined - fetches wait forever and fetch_fault is tied to 0.

module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        resetl,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [10:0] opcode,
  output logic        instr_valid,
  output logic [63:0] pc,
  input  logic        stall,
  input  logic        branch,
  input  logic        uncond_branch,
  input  logic        zero,
  input  logic [63:0] signext_imm,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;

  // Low for the single settle cycle that follows reset release.
  logic settled;

  logic        taken;
  logic [63:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
  // Count value at which one more unacknowledged cycle hits the limit.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_count;
`endif

  assign imem_addr = pc;
  assign opcode    = instr[31:21];

  // An x on branch is harmless when uncond_branch=1 because the OR dominates.
  assign taken   = uncond_branch | (branch & zero);
  assign next_pc = taken ? (pc + (signext_imm << 2)) : (pc + 64'd4);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      settled     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_count  <= 16'd0;
      fetch_fault <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (!settled) begin
            settled  <= 1'b1;
            imem_req <= 1'b1;
          end else if (imem_req && imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ISSUE;
`ifdef FETCH_TIMEOUT_EN
            wait_count  <= 16'd0;
`endif
          end
`ifdef FETCH_TIMEOUT_EN
          // A same-cycle ack is taken by the branch above, so it beats the fault.
          else if (imem_req && (wait_count == TIMEOUT_LAST)) begin
            fetch_fault <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HALT;
          end else if (imem_req) begin
            wait_count <= wait_count + 16'd1;
          end
`endif
        end
        ISSUE: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_count  <= 16'd0;
`endif
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
      endcase
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit. The bench plays instruction memory and
// the downstream control/datapath, and keeps its own notion of where the
// program counter should be from the branch rules (taken branches move by the
// offset in words, everything else moves to the next word).

module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          TIMEOUT  = 16;

  logic        clk;
  logic        resetl;
  logic        imemReq;
  logic [63:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic        instrValid;
  logic [63:0] pc;
  logic        stall;
  logic        branch;
  logic        uncondBranch;
  logic        zero;
  logic [63:0] signextImm;
  logic        fetchFault;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [63:0] modelPc;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK           (clk),
    .resetl        (resetl),
    .imem_req      (imemReq),
    .imem_addr     (imemAddr),
    .imem_ack      (imemAck),
    .imem_rdata    (imemRdata),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instrValid),
    .pc            (pc),
    .stall         (stall),
    .branch        (branch),
    .uncond_branch (uncondBranch),
    .zero          (zero),
    .signext_imm   (signextImm),
    .fetch_fault   (fetchFault)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run goes astray.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Program-order reference: where execution goes after an instruction.
  function automatic logic [63:0] nextPc(input logic [63:0] cur, input logic br,
                                         input logic ub, input logic z,
                                         input logic [63:0] imm);
    if (ub || (br && z)) return cur + imm * 64'd4;
    return cur + 64'd4;
  endfunction

  // One complete instruction: memory waits, returns the word, downstream
  // stalls a while, then resolves the branch.
  task automatic applyStimulus(input int waitCycles, input logic [31:0] word,
                               input int stallCycles, input logic br,
                               input logic ub, input logic z,
                               input logic [63:0] imm);
    logic [10:0] expOpcode;
    expOpcode = word[31:21];
    for (int d = 0; d < waitCycles; d++) begin
      checkOutput("req_wait", imemReq, 64'd1);
      checkOutput("addr_wait", imemAddr, modelPc);
      checkOutput("valid_wait", instrValid, 64'd0);
      checkOutput("fault_clear", fetchFault, 64'd0);
      imemAck   = 1'b0;
      imemRdata = $urandom;
      stepCycle();
    end
    checkOutput("req_ack", imemReq, 64'd1);
    checkOutput("addr_ack", imemAddr, modelPc);
    imemAck   = 1'b1;
    imemRdata = word;
    stepCycle();
    for (int s = 0; s <= stallCycles; s++) begin
      checkOutput("valid_issue", instrValid, 64'd1);
      checkOutput("instr_issue", instr, word);
      checkOutput("opcode_issue", opcode, expOpcode);
      checkOutput("pc_issue", pc, modelPc);
      checkOutput("req_issue", imemReq, 64'd0);
      stall        = (s < stallCycles);
      branch       = br;
      uncondBranch = ub;
      zero         = z;
      signextImm   = imm;
      imemAck      = 1'($urandom_range(0, 1));
      imemRdata    = $urandom;
      stepCycle();
    end
    stall   = 1'b0;
    imemAck = 1'b0;
    modelPc = nextPc(modelPc, br, ub, z, imm);
  endtask

  // Jump to an absolute word-aligned address with an unconditional branch.
  task automatic gotoPc(input logic [63:0] target);
    applyStimulus(0, $urandom, 0, 1'b0, 1'b1, 1'b0, (target - modelPc) >> 2);
    checkOutput("pc_goto", pc, target);
  endtask

  // Release reset mid-cycle with a stray ack present during the settle cycle.
  task automatic releaseReset();
    resetl    = 1'b1;
    imemAck   = 1'b1;
    imemRdata = $urandom;
    #1;
    checkOutput("req_settle", imemReq, 64'd0);
    stepCycle();
    imemAck = 1'b0;
    checkOutput("valid_after_settle", instrValid, 64'd0);
    checkOutput("req_after_settle", imemReq, 64'd1);
    checkOutput("addr_after_settle", imemAddr, RESET_PC);
  endtask

  initial begin
    int          r;
    logic [63:0] imm;
    resetl       = 1'b0;
    imemAck      = 1'b0;
    imemRdata    = 32'h0;
    stall        = 1'b0;
    branch       = 1'b0;
    uncondBranch = 1'b0;
    zero         = 1'b0;
    signextImm   = 64'h0;
    modelPc      = RESET_PC;

    repeat (2) stepCycle();
    checkOutput("rst_req", imemReq, 64'd0);
    checkOutput("rst_valid", instrValid, 64'd0);
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_instr", instr, 64'd0);
    checkOutput("rst_fault", fetchFault, 64'd0);
    releaseReset();

    // First instruction with a zero-wait memory.
    applyStimulus(0, 32'h8B020020, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("pc_first", pc, 64'h4);

    // Branch resolution from pc 0x40.
    gotoPc(64'h40);
    applyStimulus(0, $urandom, 0, 1'b1, 1'b0, 1'b1, -64'sd2);
    checkOutput("pc_br_taken", pc, 64'h38);
    gotoPc(64'h40);
    applyStimulus(0, $urandom, 0, 1'b1, 1'b0, 1'b0, -64'sd2);
    checkOutput("pc_br_not_taken", pc, 64'h44);
    gotoPc(64'h40);
    applyStimulus(0, $urandom, 0, 1'b0, 1'b1, 1'b0, 64'd5);
    checkOutput("pc_uncond", pc, 64'h54);

    // Slow memory and a stalled downstream.
    gotoPc(64'h10);
    applyStimulus(7, $urandom, 3, 1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("pc_after_stall", pc, 64'h14);

    // Wrap at the top of the address space.
    gotoPc(64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1, $urandom, 0, 1'b0, 1'b0, 1'b1, 64'd0);
    checkOutput("pc_wrap", pc, 64'h0);

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      r   = int'($urandom_range(0, 64)) - 32;
      imm = (i % 10 == 9) ? {$urandom, $urandom} : 64'(r);
      applyStimulus(int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 2)),
                    1'($urandom), 1'($urandom), 1'($urandom), imm);
    end

    // Reset in the middle of a pending fetch.
    gotoPc(64'h80);
    repeat (2) begin
      checkOutput("req_pending", imemReq, 64'd1);
      checkOutput("addr_pending", imemAddr, 64'h80);
      stepCycle();
    end
    resetl = 1'b0;
    #1;
    checkOutput("req_async_drop", imemReq, 64'd0);
    checkOutput("pc_async_reset", pc, RESET_PC);
    imemAck   = 1'b1;
    imemRdata = $urandom;
    stepCycle();
    checkOutput("valid_in_reset", instrValid, 64'd0);
    modelPc = RESET_PC;
    releaseReset();
    applyStimulus(0, $urandom, 0, 1'b0, 1'b0, 1'b0, 64'd0);

`ifdef FETCH_TIMEOUT_EN
    // No ack at all: fault after TIMEOUT request cycles, then frozen.
    for (int c = 0; c < TIMEOUT; c++) begin
      checkOutput("req_timeout_wait", imemReq, 64'd1);
      checkOutput("fault_timeout_wait", fetchFault, 64'd0);
      imemAck = 1'b0;
      stepCycle();
    end
    for (int c = 0; c < 3; c++) begin
      checkOutput("fault_sticky", fetchFault, 64'd1);
      checkOutput("req_halt", imemReq, 64'd0);
      checkOutput("valid_halt", instrValid, 64'd0);
      checkOutput("pc_halt", pc, modelPc);
      imemAck = 1'($urandom);
      stepCycle();
    end
    imemAck = 1'b0;
    resetl  = 1'b0;
    stepCycle();
    checkOutput("fault_reset", fetchFault, 64'd0);
    modelPc = RESET_PC;
    releaseReset();
    // Ack on exactly the last allowed cycle.
    applyStimulus(TIMEOUT - 1, $urandom, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("fault_ack_at_limit", fetchFault, 64'd0);
    checkOutput("pc_ack_at_limit", pc, RESET_PC + 64'd4);
`else
    checkOutput("fault_tied_low", fetchFault, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
